eth_tx_pkt_buf: RTL and testbench

//  Parametrised store-and-forward packet buffer on the 10GE MAC TX packet interface.

---
 rtl/eth_tx_pkt_buf.sv | 245 ++++++++++++++++++++++++
 tb/tb_eth_tx_pkt_buf.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_pkt_buf.sv
// eth_tx_pkt_buf: store-and-forward packet buffer for the 10GE MAC TX packet
// interface. Upstream words are written speculatively and committed on eop;
// only committed packets are replayed toward the MAC. Malformed or oversized
// packets are rewound out of the FIFO and counted.
//
// Handshake: an upstream word is transferred on every cycle with in_val=1.
// in_full is advisory backpressure that leaves AF_MARGIN entries of skid room.
// A word that still arrives with no room left drops its packet.
// Toward the MAC, one word is popped on each clock edge where pkt_tx_full is
// low and a committed word is waiting. pkt_tx_val marks each popped word for
// exactly one cycle. Because pkt_tx_full is only seen at the edge, the MAC
// must absorb one more word after it raises pkt_tx_full.
module eth_tx_pkt_buf #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 512,
  parameter int AF_MARGIN = 4,
  parameter int CNT_W     = 16,
  localparam int MOD_W    = $clog2(DATA_W / 8),
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_val,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [MOD_W-1:0]  in_mod,
  output logic              in_full,
  output logic [DATA_W-1:0] pkt_tx_data,
  output logic              pkt_tx_val,
  output logic              pkt_tx_sop,
  output logic              pkt_tx_eop,
  output logic [MOD_W-1:0]  pkt_tx_mod,
  input  logic              pkt_tx_full,
  output logic              pkt_avail,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  frm_err_cnt
);

  // Each entry is {eop, mod, data}. sop is implied by the word after an eop.
  localparam int EW = 1 + MOD_W + DATA_W;
  localparam logic [AW:0]    DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    MARGIN_C = (AW + 1)'(AF_MARGIN);
  localparam logic [AW:0]    PTR_ONE  = (AW + 1)'(1);
  localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wr_state_e;
  typedef enum logic       {R_IDLE, R_PKT}         rd_state_e;

  logic [EW-1:0] mem_q [DEPTH];

  // Pointers carry one extra bit so that full and empty can be told apart.
  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       cm_ptr_q, cm_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  frm_err_cnt_q, frm_err_cnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_val_q, tx_val_d;
  logic              tx_sop_q, tx_sop_d;
  logic              tx_eop_q, tx_eop_d;
  logic [MOD_W-1:0]  tx_mod_q, tx_mod_d;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [EW-1:0]     wr_entry;
  logic [MOD_W-1:0]  in_mod_masked;
  logic              do_write;
  logic [AW:0]       base_ptr;
  logic [AW:0]       base_used;
  logic              commit;
  logic              frm_inc;
  logic [1:0]        drop_inc;
  logic [CNT_W:0]    drop_sum;
  logic [EW-1:0]     rd_entry;
  logic              rd_entry_eop;
  logic              pop;
  logic              pkt_dec;
  logic [AW:0]       used;
  logic [AW:0]       free;

  // Write-side decisions: framing checks, overflow rewind and commit on eop.
  always_comb begin
    wr_state_d    = wr_state_q;
    wr_ptr_d      = wr_ptr_q;
    cm_ptr_d      = cm_ptr_q;
    wr_en         = 1'b0;
    wr_addr       = wr_ptr_q[AW-1:0];
    in_mod_masked = in_eop ? in_mod : {MOD_W{1'b0}};
    wr_entry      = {in_eop, in_mod_masked, in_data};
    do_write      = 1'b0;
    base_ptr      = wr_ptr_q;
    base_used     = '0;
    commit        = 1'b0;
    frm_inc       = 1'b0;
    drop_inc      = 2'd0;
    if (in_val) begin
      case (wr_state_q)
        W_PKT: begin
          // A sop inside a packet means the previous eop was lost: drop the
          // partial packet and restart from the committed pointer.
          if (in_sop) begin
            base_ptr = cm_ptr_q;
            wr_ptr_d = cm_ptr_q;
            frm_inc  = 1'b1;
            drop_inc = 2'd1;
          end
          do_write = 1'b1;
        end
        default: begin
          if (in_sop) begin
            do_write = 1'b1;
          end else if (wr_state_q == W_DROP) begin
            if (in_eop) wr_state_d = W_IDLE;
          end else begin
            frm_inc = 1'b1;
          end
        end
      endcase
      if (do_write) begin
        base_used = base_ptr - rd_ptr_q;
        if (base_used == DEPTH_C) begin
          // No room left: rewind the whole packet and swallow its tail.
          wr_ptr_d   = cm_ptr_q;
          drop_inc   = drop_inc + 2'd1;
          wr_state_d = in_eop ? W_IDLE : W_DROP;
        end else begin
          wr_en    = 1'b1;
          wr_addr  = base_ptr[AW-1:0];
          wr_ptr_d = base_ptr + PTR_ONE;
          if (in_eop) begin
            cm_ptr_d   = base_ptr + PTR_ONE;
            commit     = 1'b1;
            wr_state_d = W_IDLE;
          end else begin
            wr_state_d = W_PKT;
          end
        end
      end
    end
  end

  // Read side: pop one committed word per edge unless the MAC is full.
  always_comb begin
    rd_entry     = mem_q[rd_ptr_q[AW-1:0]];
    rd_entry_eop = rd_entry[EW-1];
    pop          = !pkt_tx_full && ((rd_state_q == R_PKT) || (pkt_cnt_q != '0));
    rd_state_d   = rd_state_q;
    rd_ptr_d     = rd_ptr_q;
    pkt_dec      = 1'b0;
    tx_val_d     = 1'b0;
    tx_sop_d     = tx_sop_q;
    tx_eop_d     = tx_eop_q;
    tx_mod_d     = tx_mod_q;
    tx_data_d    = tx_data_q;
    if (pop) begin
      tx_val_d  = 1'b1;
      tx_sop_d  = (rd_state_q == R_IDLE);
      tx_eop_d  = rd_entry_eop;
      tx_mod_d  = rd_entry_eop ? rd_entry[EW-2 -: MOD_W] : {MOD_W{1'b0}};
      tx_data_d = rd_entry[DATA_W-1:0];
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      if (rd_entry_eop) begin
        pkt_dec    = 1'b1;
        rd_state_d = R_IDLE;
      end else begin
        rd_state_d = R_PKT;
      end
    end
  end

  // Stored-packet count and saturating error counters.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({commit, pkt_dec})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W + 1)'(drop_inc);
    drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    frm_err_cnt_d = frm_err_cnt_q;
    if (frm_inc && (frm_err_cnt_q != {CNT_W{1'b1}})) begin
      frm_err_cnt_d = frm_err_cnt_q + CNT_ONE[CNT_W-1:0];
    end
  end

  // Occupancy includes uncommitted words so in_full protects the open packet.
  always_comb begin
    used    = wr_ptr_q - rd_ptr_q;
    free    = DEPTH_C - used;
    in_full = (free <= MARGIN_C);
  end

  // Packet storage; contents are not reset, pointer reset empties it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_entry;
  end

  // All control state, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q    <= W_IDLE;
      rd_state_q    <= R_IDLE;
      wr_ptr_q      <= '0;
      cm_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pkt_cnt_q     <= '0;
      drop_cnt_q    <= '0;
      frm_err_cnt_q <= '0;
      tx_data_q     <= '0;
      tx_val_q      <= 1'b0;
      tx_sop_q      <= 1'b0;
      tx_eop_q      <= 1'b0;
      tx_mod_q      <= '0;
    end else begin
      wr_state_q    <= wr_state_d;
      rd_state_q    <= rd_state_d;
      wr_ptr_q      <= wr_ptr_d;
      cm_ptr_q      <= cm_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pkt_cnt_q     <= pkt_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      frm_err_cnt_q <= frm_err_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_val_q      <= tx_val_d;
      tx_sop_q      <= tx_sop_d;
      tx_eop_q      <= tx_eop_d;
      tx_mod_q      <= tx_mod_d;
    end
  end

  assign pkt_tx_data = tx_data_q;
  assign pkt_tx_val  = tx_val_q;
  assign pkt_tx_sop  = tx_sop_q;
  assign pkt_tx_eop  = tx_eop_q;
  assign pkt_tx_mod  = tx_mod_q;
  assign pkt_avail   = (pkt_cnt_q != '0);
  assign drop_cnt    = drop_cnt_q;
  assign frm_err_cnt = frm_err_cnt_q;

endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// tb_eth_tx_pkt_buf: directed packets against a queue-level model of the
// buffer: complete packets in, the same words out, malformed/oversized
// packets dropped and counted.
module tb_eth_tx_pkt_buf;
  localparam int DATA_W    = 64;
  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 4;
  localparam int CNT_W     = 16;
  localparam int MOD_W     = 3;
  localparam int EW        = 2 + MOD_W + DATA_W;  // {sop, eop, mod, data}

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_val = 1'b0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic [MOD_W-1:0]  in_mod = '0;
  logic              in_full;
  logic [DATA_W-1:0] pkt_tx_data;
  logic              pkt_tx_val;
  logic              pkt_tx_sop;
  logic              pkt_tx_eop;
  logic [MOD_W-1:0]  pkt_tx_mod;
  logic              pkt_tx_full = 1'b0;
  logic              pkt_avail;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  frm_err_cnt;

  eth_tx_pkt_buf #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_val(in_val), .in_sop(in_sop), .in_eop(in_eop),
    .in_mod(in_mod), .in_full(in_full),
    .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_full(pkt_tx_full),
    .pkt_avail(pkt_avail), .drop_cnt(drop_cnt), .frm_err_cnt(frm_err_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state / scoreboard ----------------
  logic [EW-1:0] exp_q[$];   // committed words not yet seen at the output
  logic [EW-1:0] cur_q[$];   // words of the packet currently being received
  int  store_words  = 0;     // words the buffer holds, committed or not
  int  model_pkts   = 0;
  int  exp_drop     = 0;
  int  exp_frm      = 0;
  bit  in_pkt       = 1'b0;
  bit  dropping     = 1'b0;
  bit  exp_pop      = 1'b0;
  int  cyc          = 0;
  int  n_vec        = 0;
  int  n_fail       = 0;
  int  emitted      = 0;
  int  prev_sop_cyc = 0;
  int  last_sop_cyc = 0;
  int  last_eop_cyc = 0;

  function automatic logic [EW-1:0] mk(bit sop, bit eop, logic [MOD_W-1:0] mod,
                                       logic [DATA_W-1:0] d);
    logic [MOD_W-1:0] m;
    m = eop ? mod : '0;
    return {sop, eop, m, d};
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level rules for one accepted upstream word.
  task automatic model_word(bit sop, bit eop, logic [MOD_W-1:0] mod, logic [DATA_W-1:0] d);
    bit wr;
    wr = 1'b0;
    if (in_pkt && sop) begin
      exp_frm++;
      exp_drop++;
      store_words -= cur_q.size();
      cur_q.delete();
      in_pkt = 1'b0;
    end
    if (in_pkt || sop) wr = 1'b1;
    else if (dropping) begin
      if (eop) dropping = 1'b0;
    end else exp_frm++;
    if (wr) begin
      dropping = 1'b0;
      if (store_words == DEPTH) begin
        exp_drop++;
        store_words -= cur_q.size();
        cur_q.delete();
        in_pkt   = 1'b0;
        dropping = !eop;
      end else begin
        cur_q.push_back(mk(cur_q.size() == 0, eop, mod, d));
        store_words++;
        if (eop) begin
          foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
          cur_q.delete();
          model_pkts++;
          in_pkt = 1'b0;
        end else begin
          in_pkt = 1'b1;
        end
      end
    end
  endtask

  // Model update: what must pop at this edge, then absorb the input word.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_pop = 1'b0;
    end else begin
      exp_pop = !pkt_tx_full && (exp_q.size() > 0);
      if (in_val) model_word(in_sop, in_eop, in_mod, in_data);
    end
  end

  // Compare process: every cycle, away from the edge.
  always begin
    logic [EW-1:0] w;
    @(posedge clk);
    #3;
    chk("pkt_tx_val", pkt_tx_val, exp_pop);
    if (pkt_tx_val) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL spurious_word: got %0h, expected no word", pkt_tx_data);
      end else begin
        w = exp_q.pop_front();
        chk("pkt_tx_word", {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data}, w);
        store_words--;
        emitted++;
        if (w[EW-2]) model_pkts--;
        if (w[EW-1]) begin
          prev_sop_cyc = last_sop_cyc;
          last_sop_cyc = cyc;
        end
      end
    end
    chk("pkt_avail", pkt_avail, model_pkts > 0);
    chk("in_full", in_full, (DEPTH - store_words) <= AF_MARGIN);
    chk("drop_cnt", drop_cnt, exp_drop[CNT_W-1:0]);
    chk("frm_err_cnt", frm_err_cnt, exp_frm[CNT_W-1:0]);
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(bit sop, bit eop, logic [MOD_W-1:0] mod, logic [DATA_W-1:0] d);
    @(negedge clk);
    in_val  = 1'b1;
    in_sop  = sop;
    in_eop  = eop;
    in_mod  = mod;
    in_data = d;
  endtask

  // Lets the last driven word be sampled, records that edge, goes idle.
  task automatic end_burst();
    @(posedge clk);
    #1;
    last_eop_cyc = cyc;
    in_val = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic send_pkt(int n, logic [MOD_W-1:0] mod, logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) send_word(i == 0, i == n - 1, mod, base + DATA_W'(i));
    end_burst();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d words still pending, 0 required", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_val = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    pkt_tx_full = 1'b0;
    #1;
    exp_q.delete();
    cur_q.delete();
    store_words = 0;
    model_pkts  = 0;
    exp_drop    = 0;
    exp_frm     = 0;
    in_pkt      = 1'b0;
    dropping    = 1'b0;
    chk("rst_val", pkt_tx_val, 0);
    chk("rst_sop", pkt_tx_sop, 0);
    chk("rst_eop", pkt_tx_eop, 0);
    chk("rst_mod", pkt_tx_mod, 0);
    chk("rst_data", pkt_tx_data, 0);
    chk("rst_avail", pkt_avail, 0);
    chk("rst_in_full", in_full, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_frm", frm_err_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w0;
    do_reset();
    repeat (2) @(negedge clk);

    // 3-word packet, mod=5, MAC never full
    w0 = emitted;
    send_pkt(3, 3'd5, 64'hA000_0000_0000_0010);
    chk("t1_avail_after_eop", pkt_avail, 1);
    chk("t1_no_val_yet", pkt_tx_val, 0);
    wait_drain();
    chk("t1_latency", last_sop_cyc, last_eop_cyc + 1);
    chk("t1_words", emitted - w0, 3);

    // two 1-word packets back-to-back
    w0 = emitted;
    send_word(1'b1, 1'b1, 3'd1, 64'hB000_0000_0000_0001);
    send_word(1'b1, 1'b1, 3'd0, 64'hB000_0000_0000_0002);
    end_burst();
    wait_drain();
    chk("t2_back_to_back", last_sop_cyc - prev_sop_cyc, 1);
    chk("t2_latency", last_sop_cyc, last_eop_cyc + 1);
    chk("t2_words", emitted - w0, 2);
    chk("t2_avail_low", pkt_avail, 0);

    // MAC full held 10 cycles mid-packet
    w0 = emitted;
    send_pkt(6, 3'd3, 64'hC000_0000_0000_0100);
    @(negedge clk);
    @(negedge clk);
    pkt_tx_full = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3_hold_words", emitted - w0, 1);
    pkt_tx_full = 1'b0;
    wait_drain();
    chk("t3_words", emitted - w0, 6);

    // 20-word packet into a 16-deep buffer, then a clean 4-word packet
    w0 = emitted;
    send_pkt(20, 3'd2, 64'hD000_0000_0000_1000);
    @(negedge clk);
    chk("t4_drop", drop_cnt, 1);
    chk("t4_empty_avail", pkt_avail, 0);
    chk("t4_empty_full", in_full, 0);
    send_pkt(4, 3'd6, 64'hE000_0000_0000_2000);
    wait_drain();
    chk("t4_words", emitted - w0, 4);

    // missing eop: sop, word, sop, eop
    w0 = emitted;
    send_word(1'b1, 1'b0, 3'd0, 64'hF000_0000_0000_0001);
    send_word(1'b0, 1'b0, 3'd0, 64'hF000_0000_0000_0002);
    send_word(1'b1, 1'b0, 3'd0, 64'hF000_0000_0000_0003);
    send_word(1'b0, 1'b1, 3'd7, 64'hF000_0000_0000_0004);
    end_burst();
    wait_drain();
    chk("t5_frm", frm_err_cnt, 1);
    chk("t5_drop", drop_cnt, 2);
    chk("t5_words", emitted - w0, 2);
    // stray non-sop word while idle
    send_word(1'b0, 1'b0, 3'd0, 64'h1234_5678_9ABC_DEF0);
    end_burst();
    @(negedge clk);
    chk("t5_stray_frm", frm_err_cnt, 2);

    // reset pulsed mid-output, then a normal packet
    send_pkt(8, 3'd4, 64'h7000_0000_0000_3000);
    @(negedge clk);
    @(negedge clk);
    do_reset();
    repeat (2) @(negedge clk);
    w0 = emitted;
    send_pkt(3, 3'd2, 64'h8000_0000_0000_4000);
    wait_drain();
    chk("t6_latency", last_sop_cyc, last_eop_cyc + 1);
    chk("t6_words", emitted - w0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Absolute time bound for the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
